sccb_init_arb: RTL and testbench

Boot-time sequencer and arbiter for the single SCCB master (`sccb`). After reset it waits a settling delay, then writes an external table of NUM_REGS {register address, data} pairs to the camera. When the table is done it hands the SCCB master to the host path (the PC packet interpreter), which uses it for ad-hoc register reads and writes. It sits between `pcpacket`'s request/ack/done signals and the `sccb` instance, and muxes one onto the other.

---
 rtl/sccb_init_arb.sv | 186 ++++++++++++++++++
 tb/tb_sccb_init_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_arb.sv
// SCCB boot sequencer: writes a register table, then grants the master to the host.
// Optional read-back verify compiled in with SCCB_INIT_VERIFY_EN.
module sccb_init_arb #(
  parameter int NUM_REGS    = 16,
  parameter int IDX_W       = 8,
  parameter int WAIT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reinit,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [7:0]       tbl_addr,
  input  logic [7:0]       tbl_data,
  input  logic             h_read_request,
  input  logic             h_write_request,
  input  logic [7:0]       h_addr,
  input  logic [7:0]       h_write_data,
  output logic             h_request_ack,
  output logic             h_done,
  output logic [7:0]       h_read_data,
  output logic             read_request,
  output logic             write_request,
  output logic [7:0]       sccb_addr,
  output logic [7:0]       write_data,
  input  logic             request_ack,
  input  logic             done,
  input  logic [7:0]       read_data,
  output logic             init_busy,
  output logic             init_done,
  output logic             init_err
);

  typedef enum logic [3:0] {
    S_WAIT,
    S_IREQ,
    S_IACK,
    S_IDONE,
`ifdef SCCB_INIT_VERIFY_EN
    S_VREQ,
    S_VACK,
    S_VDONE,
`endif
    S_HOST,
    S_HBUSY
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        wr_q;
  logic        rd_q;
  logic        done_q;
  logic        pend;
  logic        done_rise;
  logic        last;
  logic        in_host;
  logic        grant;

  assign done_rise = done & ~done_q;
  assign last      = (tbl_idx == IDX_W'(NUM_REGS - 1));
  assign in_host   = (state == S_HOST) || (state == S_HBUSY);
  // a reinit in HOST must not leak a host request onto the bus
  assign grant     = ((state == S_HOST) && !reinit) ||
                     (state == S_HBUSY);

  assign read_request  = grant ? h_read_request  : rd_q;
  assign write_request = grant ? h_write_request : wr_q;
  assign sccb_addr     = grant ? h_addr          : addr_q;
  assign write_data    = grant ? h_write_data    : wdata_q;
  assign h_request_ack = grant & request_ack;
  assign h_done        = in_host & done;
  assign h_read_data   = in_host ? read_data : 8'h00;

`ifndef SCCB_INIT_VERIFY_EN
  assign init_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT;
      cnt       <= '0;
      tbl_idx   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      done_q    <= 1'b0;
      pend      <= 1'b0;
      init_busy <= 1'b1;
      init_done <= 1'b0;
`ifdef SCCB_INIT_VERIFY_EN
      init_err  <= 1'b0;
`endif
    end else begin
      done_q <= done;
      unique case (state)
        S_WAIT: begin
          if (cnt == 16'(WAIT_CYCLES - 1)) state <= S_IREQ;
          else cnt <= cnt + 16'd1;
        end
        S_IREQ: begin
          addr_q  <= tbl_addr;
          wdata_q <= tbl_data;
          wr_q    <= 1'b1;
          state   <= S_IACK;
        end
        S_IACK: begin
          if (request_ack) begin
            wr_q  <= 1'b0;
            state <= S_IDONE;
          end
        end
        S_IDONE: begin
          if (done_rise) begin
`ifdef SCCB_INIT_VERIFY_EN
            state <= S_VREQ;
`else
            if (last) begin
              state     <= S_HOST;
              init_done <= 1'b1;
              init_busy <= 1'b0;
            end else begin
              tbl_idx <= tbl_idx + 1'b1;
              state   <= S_IREQ;
            end
`endif
          end
        end
`ifdef SCCB_INIT_VERIFY_EN
        S_VREQ: begin
          rd_q  <= 1'b1;
          state <= S_VACK;
        end
        S_VACK: begin
          if (request_ack) begin
            rd_q  <= 1'b0;
            state <= S_VDONE;
          end
        end
        S_VDONE: begin
          if (done_rise) begin
            if (read_data != tbl_data) init_err <= 1'b1;
            if (last) begin
              state     <= S_HOST;
              init_done <= 1'b1;
              init_busy <= 1'b0;
            end else begin
              tbl_idx <= tbl_idx + 1'b1;
              state   <= S_IREQ;
            end
          end
        end
`endif
        S_HOST: begin
          if (reinit) begin
            state     <= S_WAIT;
            cnt       <= '0;
            tbl_idx   <= '0;
            init_done <= 1'b0;
            init_busy <= 1'b1;
          end else if (request_ack) begin
            state <= S_HBUSY;
          end
        end
        S_HBUSY: begin
          if (reinit) pend <= 1'b1;
          if (done_rise) begin
            if (pend || reinit) begin
              state     <= S_WAIT;
              cnt       <= '0;
              tbl_idx   <= '0;
              init_done <= 1'b0;
              init_busy <= 1'b1;
              pend      <= 1'b0;
            end else begin
              state <= S_HOST;
            end
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_arb.sv
// Directed bench for sccb_init_arb with a behavioural SCCB master model.
// Build with SCCB_INIT_VERIFY_EN to exercise the read-back path.
module tb_sccb_init_arb;

  localparam int WC = 4;
  localparam int NR = 3;
`ifdef SCCB_INIT_VERIFY_EN
  localparam int NTX = 6;
  localparam logic EXP_ERR = 1'b1;
`else
  localparam int NTX = 3;
  localparam logic EXP_ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       reinit = 1'b0;
  logic [7:0] tbl_idx;
  logic [7:0] tbl_addr;
  logic [7:0] tbl_data;
  logic       h_read_request = 1'b0;
  logic       h_write_request = 1'b0;
  logic [7:0] h_addr = 8'h00;
  logic [7:0] h_write_data = 8'h00;
  logic       h_request_ack;
  logic       h_done;
  logic [7:0] h_read_data;
  logic       read_request;
  logic       write_request;
  logic [7:0] sccb_addr;
  logic [7:0] write_data;
  logic       request_ack;
  logic       done;
  logic [7:0] read_data;
  logic       init_busy;
  logic       init_done;
  logic       init_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sccb_init_arb #(
    .NUM_REGS(NR),
    .IDX_W(8),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .reinit(reinit),
    .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .h_read_request(h_read_request),
    .h_write_request(h_write_request),
    .h_addr(h_addr),
    .h_write_data(h_write_data),
    .h_request_ack(h_request_ack),
    .h_done(h_done),
    .h_read_data(h_read_data),
    .read_request(read_request),
    .write_request(write_request),
    .sccb_addr(sccb_addr),
    .write_data(write_data),
    .request_ack(request_ack),
    .done(done),
    .read_data(read_data),
    .init_busy(init_busy),
    .init_done(init_done),
    .init_err(init_err)
  );

  always_comb begin
    tbl_addr = 8'h00;
    tbl_data = 8'h00;
    case (tbl_idx)
      8'd0: begin tbl_addr = 8'h12; tbl_data = 8'h80; end
      8'd1: begin tbl_addr = 8'h11; tbl_data = 8'h01; end
      8'd2: begin tbl_addr = 8'h3A; tbl_data = 8'h04; end
      default: ;
    endcase
  end

  // SCCB model: ack 2 cycles after accept, done 10 cycles after accept
  logic [7:0]  regs [256];
  logic [15:0] wlog [$];
  logic        busy;
  int          mcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      mcnt        <= 0;
      request_ack <= 1'b0;
      done        <= 1'b0;
      read_data   <= 8'h00;
    end else begin
      request_ack <= 1'b0;
      if (!busy) begin
        if (read_request || write_request) begin
          busy <= 1'b1;
          mcnt <= 0;
          done <= 1'b0;
          if (write_request) begin
            regs[sccb_addr] <= write_data;
            wlog.push_back({sccb_addr, write_data});
          end else begin
            read_data <= (sccb_addr == 8'h11) ? 8'h00 : regs[sccb_addr];
          end
        end
      end else begin
        mcnt <= mcnt + 1;
        if (mcnt == 1) request_ack <= 1'b1;
        if (mcnt == 9) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

  logic done_d = 1'b0;
  int   rises = 0;
  logic early_ack = 1'b0;
  logic bad_hdone = 1'b0;

  always @(posedge clk) begin
    done_d <= done;
    if (done && !done_d) rises <= rises + 1;
    if (h_request_ack && !init_done) early_ack <= 1'b1;
    if (h_done && !init_done) bad_hdone <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_startup(input string tag);
    for (int c = 1; c <= WC + 1; c++) begin
      @(posedge clk);
      #1;
      chk(tag, {31'd0, write_request}, {31'd0, c == WC + 1});
    end
  endtask

  int r0;

  initial begin
    h_write_request = 1'b1;
    h_addr          = 8'h55;
    h_write_data    = 8'hAA;
    #12;
    chk("rst_wr", {31'd0, write_request}, 32'd0);
    chk("rst_rd", {31'd0, read_request}, 32'd0);
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    chk("rst_done", {31'd0, init_done}, 32'd0);
    chk("rst_err", {31'd0, init_err}, 32'd0);
    chk("rst_hack", {31'd0, h_request_ack}, 32'd0);
    chk("rst_hdone", {31'd0, h_done}, 32'd0);
    chk("rst_idx", {24'd0, tbl_idx}, 32'd0);
    #10;
    rst_n = 1'b1;
    r0 = rises;
    check_startup("first_wr");
    chk("first_addr", {24'd0, sccb_addr}, 32'h12);

    for (int i = 0; i < 400 && !init_done; i++) begin
      @(posedge clk);
      #1;
    end
    chk("init_done1", {31'd0, init_done}, 32'd1);
    chk("init_busy1", {31'd0, init_busy}, 32'd0);
    chk("rises1", rises - r0, NTX);
    chk("idx_last", {24'd0, tbl_idx}, 32'd2);
    chk("wlog0", {16'd0, wlog[0]}, 32'h1280);
    chk("wlog1", {16'd0, wlog[1]}, 32'h1101);
    chk("wlog2", {16'd0, wlog[2]}, 32'h3A04);
    chk("err1", {31'd0, init_err}, {31'd0, EXP_ERR});

    chk("grant_wr", {31'd0, write_request}, 32'd1);
    chk("grant_addr", {24'd0, sccb_addr}, 32'h55);
    chk("grant_data", {24'd0, write_data}, 32'hAA);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("hack_eq", {31'd0, h_request_ack}, {31'd0, request_ack});
      if (request_ack) break;
    end
    chk("hack_seen", {31'd0, h_request_ack}, 32'd1);
    h_write_request = 1'b0;

    @(posedge clk);
    #1;
    reinit = 1'b1;
    @(posedge clk);
    #1;
    reinit = 1'b0;
    chk("hbusy_done0", {31'd0, init_done}, 32'd1);
    for (int i = 0; i < 30 && !h_done; i++) begin
      @(posedge clk);
      #1;
    end
    chk("hdone_seen", {31'd0, h_done}, 32'd1);
    @(posedge clk);
    #1;
    chk("ri_done", {31'd0, init_done}, 32'd0);
    chk("ri_busy", {31'd0, init_busy}, 32'd1);
    chk("ri_idx", {24'd0, tbl_idx}, 32'd0);
    chk("ri_hdone", {31'd0, h_done}, 32'd0);
    chk("host_wlog", {16'd0, wlog[3]}, 32'h55AA);

    for (int i = 0; i < 400 && !init_done; i++) begin
      @(posedge clk);
      #1;
    end
    chk("init_done2", {31'd0, init_done}, 32'd1);
    chk("err2", {31'd0, init_err}, {31'd0, EXP_ERR});
    chk("wlog4", {16'd0, wlog[4]}, 32'h1280);
    chk("wlog5", {16'd0, wlog[5]}, 32'h1101);
    chk("wlog6", {16'd0, wlog[6]}, 32'h3A04);

    reinit = 1'b1;
    @(posedge clk);
    #1;
    reinit = 1'b0;
    chk("hri_busy", {31'd0, init_busy}, 32'd1);
    chk("hri_done", {31'd0, init_done}, 32'd0);
    for (int i = 0; i < 200 && !(tbl_idx == 8'd1 && write_request); i++) begin
      @(posedge clk);
      #1;
    end
    chk("iack1_wr", {31'd0, write_request}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", {31'd0, write_request}, 32'd0);
    chk("mid_rst_idx", {24'd0, tbl_idx}, 32'd0);
    #1;
    rst_n = 1'b1;
    check_startup("restart_wr");
    chk("restart_addr", {24'd0, sccb_addr}, 32'h12);
    chk("restart_idx", {24'd0, tbl_idx}, 32'd0);

    chk("early_ack", {31'd0, early_ack}, 32'd0);
    chk("hdone_gate", {31'd0, bad_hdone}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
